// File: rtl/pfiform_pop_unpacker.sv
// pfiform_pop_unpacker: pops words from PFIFORM into a 2-slot buffer and streams them out one element per cycle
module pfiform_pop_unpacker #(
  parameter int ELEM_W    = 6,
  parameter int MAX_ELEMS = 32,
  parameter int CNT_W     = 5
) (
  input  logic                          i_core_clk,
  input  logic                          i_rx_rst,
  input  logic [CNT_W-1:0]              cfg_pop_amount,
  output logic [CNT_W-1:0]              PopAmout,
  output logic                          PopPermit,
  input  logic                          PopEnable,
  input  logic [ELEM_W*MAX_ELEMS-1:0]   PopData,
  output logic [ELEM_W-1:0]             o_elem,
  output logic                          o_elem_valid,
  input  logic                          i_elem_ready,
  output logic                          o_elem_last,
  output logic [CNT_W-1:0]              o_elem_idx,
  output logic [1:0]                    o_occupancy,
  output logic                          o_proto_err
);
  logic [MAX_ELEMS-1:0][ELEM_W-1:0] word [2];
  logic [CNT_W-1:0] cnt [2];
  logic wp, rp, err, cap, drain, valid, last;
  logic [1:0] occ, occ_next;
  logic [CNT_W-1:0] idx;
  always_comb begin
    valid    = occ != 2'd0;
    last     = valid && idx == cnt[rp];
    cap      = PopEnable && PopPermit;
    drain    = last && i_elem_ready;
    occ_next = occ + 2'(cap) - 2'(drain);
  end
  assign o_elem       = valid ? word[rp][idx] : '0;
  assign o_elem_valid = valid;
  assign o_elem_last  = last;
  assign o_elem_idx   = idx;
  assign o_occupancy  = occ;
  assign o_proto_err  = err;
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      word      <= '{default: '0};
      cnt       <= '{default: '0};
      wp        <= 1'b0;
      rp        <= 1'b0;
      occ       <= 2'd0;
      idx       <= '0;
      err       <= 1'b0;
      PopAmout  <= '0;
      PopPermit <= 1'b0;
    end else begin
      if (cap) begin
        word[wp] <= PopData;
        cnt[wp]  <= PopAmout;
        wp       <= ~wp;
      end
      if (valid && i_elem_ready) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) rp <= ~rp;
      end
      occ       <= occ_next;
      PopPermit <= occ_next < 2'd2;
      // count only changes while idle so each word keeps the count it was popped with
      if (occ == 2'd0 && !PopEnable) PopAmout <= cfg_pop_amount;
      if (PopEnable && !PopPermit) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pfiform_pop_unpacker.sv
// tb_pfiform_pop_unpacker: directed checks of pop handshake, unpacking, backpressure, config latching, errors and reset
module tb_pfiform_pop_unpacker;
  logic clk = 0, rst = 1, en = 0, ready = 0;
  logic [4:0] cfg = 5'd9;
  logic [191:0] data = '0;
  logic [4:0] amt, idx;
  logic permit, valid, last, err;
  logic [5:0] elem;
  logic [1:0] occ;
  int n_cmp = 0, n_err = 0;

  pfiform_pop_unpacker dut (
    .i_core_clk(clk), .i_rx_rst(rst), .cfg_pop_amount(cfg), .PopAmout(amt),
    .PopPermit(permit), .PopEnable(en), .PopData(data), .o_elem(elem),
    .o_elem_valid(valid), .i_elem_ready(ready), .o_elem_last(last),
    .o_elem_idx(idx), .o_occupancy(occ), .o_proto_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] mkword(input int base);
    logic [191:0] w;
    for (int k = 0; k < 32; k++) w[k*6 +: 6] = 6'((base + k) % 64);
    return w;
  endfunction

  initial begin
    int exp, sent, maxocc, lastcnt, n;
    tick(); tick();
    chk("rst_permit", permit, 0); chk("rst_valid", valid, 0); chk("rst_last", last, 0);
    chk("rst_occ", occ, 0); chk("rst_err", err, 0); chk("rst_amt", amt, 0);
    chk("rst_elem", elem, 0); chk("rst_idx", idx, 0);
    rst = 0; tick();
    chk("post_rst_permit", permit, 1); chk("post_rst_amt", amt, 9);

    // single 10-element word at full rate
    en = 1; data = mkword(0); ready = 1; tick(); en = 0;
    chk("t1_occ", occ, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t1_valid", valid, 1); chk("t1_elem", elem, i);
      chk("t1_last", last, i == 9); chk("t1_permit", permit, 1);
      tick();
    end
    chk("t1_done_valid", valid, 0); chk("t1_done_occ", occ, 0);

    // three 32-element words back-to-back
    cfg = 31; tick(); chk("t2_amt", amt, 31);
    sent = 0; exp = 0; maxocc = 0;
    for (int c = 0; c < 200 && exp < 96; c++) begin
      en = (sent < 3) && permit;
      if (en) begin data = mkword(sent * 32); sent++; end
      tick();
      if (occ > maxocc) maxocc = occ;
      chk("t2_permit", permit, occ != 2);
      if (valid) begin chk("t2_elem", elem, exp % 64); exp++; end
      else if (exp > 0) chk("t2_gap", valid, 1);
    end
    en = 0; tick();
    chk("t2_count", exp, 96); chk("t2_maxocc", maxocc, 2);
    chk("t2_err", err, 0); chk("t2_empty", occ, 0);

    // 7-element word under 1,0,0,1 backpressure
    cfg = 6; tick(); chk("t3_amt", amt, 6);
    en = 1; data = mkword(0); ready = 0; tick(); en = 0;
    exp = 0; lastcnt = 0;
    for (int p = 0; p < 60 && exp < 7; p++) begin
      ready = (p % 4 == 0) || (p % 4 == 3);
      chk("t3_valid", valid, 1); chk("t3_elem", elem, exp); chk("t3_last", last, exp == 6);
      if (ready) begin if (last) lastcnt++; exp++; end
      tick();
    end
    chk("t3_lastcnt", lastcnt, 1); chk("t3_valid_end", valid, 0);

    // config change latched only once idle
    ready = 1; cfg = 9; tick(); chk("t4_amt9", amt, 9);
    en = 1; data = mkword(0); tick(); en = 0; cfg = 18;
    for (int c = 0; c < 20 && valid; c++) begin
      chk("t4_amt_hold", amt, 9); chk("t4_elem", elem, c); tick();
    end
    chk("t4_idle_valid", valid, 0); chk("t4_amt_still9", amt, 9);
    tick(); chk("t4_amt18", amt, 18);
    en = 1; data = mkword(0); tick(); en = 0;
    n = 0;
    for (int c = 0; c < 40 && valid; c++) begin
      chk("t4b_elem", elem, n); chk("t4b_last", last, n == 18); n++; tick();
    end
    chk("t4b_count", n, 19);

    // pop while full: dropped word, sticky error
    ready = 0;
    en = 1; data = mkword(0); tick();
    data = mkword(10); tick();
    chk("t5_permit", permit, 0); chk("t5_occ_full", occ, 2);
    data = mkword(40); tick(); en = 0;
    chk("t5_err", err, 1); chk("t5_occ_kept", occ, 2);
    tick(); chk("t5_err_sticky", err, 1);
    ready = 1; n = 0;
    for (int c = 0; c < 60 && valid; c++) begin
      chk("t5_elem", elem, n < 19 ? n : n - 19 + 10); n++; tick();
    end
    chk("t5_count", n, 38); chk("t5_err_end", err, 1);

    // reset mid-word
    en = 1; data = mkword(0); tick(); en = 0;
    for (int c = 0; c < 5; c++) tick();
    chk("t6_idx5", idx, 5);
    rst = 1; tick();
    chk("t6_valid", valid, 0); chk("t6_occ", occ, 0); chk("t6_err", err, 0);
    rst = 0; tick(); chk("t6_permit", permit, 1);
    en = 1; data = mkword(20); tick(); en = 0;
    chk("t6_idx0", idx, 0); chk("t6_elem", elem, 20); chk("t6_valid_new", valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
